// File: rtl/psu_seq_pkg.sv
// Shared widths, opcode encodings and the PSU state type for the PSU sequencer.
package psu_seq_pkg;

  localparam int NUM_QB     = 8;
  localparam int NUM_QBCTRL = 4;
  localparam int NUM_UC     = 2;
  localparam int NUM_UCC    = 1;
  localparam int CODE_DIST  = 3;
  localparam int OPCODE_BW  = 4;
  localparam int IDLEN_BW   = 4;
  localparam int ROUND_BW   = 4;
  localparam int QDEPTH     = 4;

  localparam int QBADDR_BW  = (NUM_QB > 1) ? $clog2(NUM_QB) : 1;
  localparam int UCADDR_BW  = (NUM_UC > 1) ? $clog2(NUM_UC) : 1;
  localparam int QCNT_BW    = $clog2(QDEPTH) + 1;

  typedef enum logic [OPCODE_BW-1:0] {
    OP_NOP     = 4'd0,
    OP_LQI     = 4'd1,
    OP_LQM_X   = 4'd2,
    OP_LQM_Z   = 4'd3,
    OP_MERGE   = 4'd4,
    OP_SPLIT   = 4'd5,
    OP_RUN_ESM = 4'd6
  } psu_opcode_e;

  localparam logic [OPCODE_BW-1:0] OPCODE_NOP = OP_NOP;

  typedef enum logic {
    PSU_READY   = 1'b0,
    PSU_RUNNING = 1'b1
  } psu_state_e;

  typedef struct packed {
    logic [OPCODE_BW-1:0] opcode;
    logic [IDLEN_BW-1:0]  id_len;
  } opq_entry_t;

  // A zero patch count still means one patch to the datapath.
  function automatic logic [IDLEN_BW-1:0] present_id_len(input logic [IDLEN_BW-1:0] raw);
    return (raw == '0) ? IDLEN_BW'(1) : raw;
  endfunction

endpackage

// File: rtl/psu_opq.sv
// PSU opcode queue: synchronous FIFO with occupancy count.
// 1-cycle push-to-head latency; in_rdy_o drops when full, pop on empty is ignored.
module psu_opq #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  input  logic [W-1:0]             in_dat_i,
  input  logic                     out_rdy_i,
  output logic [W-1:0]             out_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign in_rdy_o  = (count_q != FULL);
  assign push      = in_vld_i & in_rdy_o;
  assign pop       = out_rdy_i & (count_q != '0);
  assign out_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dat_i;
  end

endmodule

// File: rtl/psu_seq.sv
// PSU sequencer: opcode queue, sweep counters and state register driven by decoder next_* pulses.
// Counters/state update 1 cycle after their pulse; done is a 1-cycle pulse after retire; in_ready=0 when queue full.
module psu_seq
  import psu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_BW-1:0] in_opcode,
  input  logic [IDLEN_BW-1:0]  in_id_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 next_uc,
  input  logic                 next_pch,
  input  logic                 next_id,
  input  logic                 next_round,
  input  logic                 next_opcode,
  input  logic                 next_state,
  output logic                 psu_valid,
  output logic [OPCODE_BW-1:0] opcode_running,
  output logic [IDLEN_BW-1:0]  id_len,
  output logic                 state,
  output logic [QBADDR_BW-1:0] qb_counter0,
  output logic [UCADDR_BW-1:0] uc_counter0,
  output logic [IDLEN_BW-1:0]  id_counter,
  output logic [ROUND_BW-1:0]  round_counter,
  output logic                 done_valid,
  output logic [OPCODE_BW-1:0] done_opcode,
  output logic                 err_underflow
);

  localparam logic [QBADDR_BW:0] QB_STRIDE = (QBADDR_BW+1)'(NUM_QBCTRL);
  localparam logic [QBADDR_BW:0] QB_WRAP   = (QBADDR_BW+1)'(NUM_QB);
  localparam logic [UCADDR_BW:0] UC_STRIDE = (UCADDR_BW+1)'(NUM_UCC);
  localparam logic [UCADDR_BW:0] UC_WRAP   = (UCADDR_BW+1)'(NUM_UC);

  opq_entry_t           in_entry, head;
  logic [QCNT_BW-1:0]   opq_count;
  logic                 pop;

  psu_state_e           state_q, state_d;
  logic [QBADDR_BW-1:0] qb_q, qb_d, qb_step;
  logic [UCADDR_BW-1:0] uc_q, uc_d, uc_step;
  logic [IDLEN_BW-1:0]  id_q, id_d;
  logic [ROUND_BW-1:0]  round_q, round_d;
  logic [QBADDR_BW:0]   qb_sum;
  logic [UCADDR_BW:0]   uc_sum;
  logic                 done_vld_q, done_vld_d;
  logic [OPCODE_BW-1:0] done_op_q, done_op_d;
  logic                 err_q, err_d;

  assign in_entry = '{opcode: in_opcode, id_len: in_id_len};

  psu_opq #(
    .W     ($bits(opq_entry_t)),
    .DEPTH (QDEPTH)
  ) u_opq (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (in_valid),
    .in_rdy_o  (in_ready),
    .in_dat_i  (in_entry),
    .out_rdy_i (pop),
    .out_dat_o (head),
    .count_o   (opq_count)
  );

  assign psu_valid      = (opq_count != '0);
  assign pop            = next_opcode & psu_valid;
  assign opcode_running = psu_valid ? head.opcode : OPCODE_NOP;
  assign id_len         = psu_valid ? present_id_len(head.id_len) : '0;

  // Sweep bases fold back to zero rather than wrapping through the address width.
  assign qb_sum  = {1'b0, qb_q} + QB_STRIDE;
  assign uc_sum  = {1'b0, uc_q} + UC_STRIDE;
  assign qb_step = (qb_sum >= QB_WRAP) ? '0 : qb_sum[QBADDR_BW-1:0];
  assign uc_step = (uc_sum >= UC_WRAP) ? '0 : uc_sum[UCADDR_BW-1:0];

  always_comb begin
    state_d    = next_state ? PSU_RUNNING : PSU_READY;
    qb_d       = qb_q;
    uc_d       = uc_q;
    id_d       = id_q;
    round_d    = round_q;
    done_vld_d = pop;
    done_op_d  = pop ? head.opcode : OPCODE_NOP;
    err_d      = err_q | (next_opcode & ~psu_valid);
    if (state_q == PSU_RUNNING && psu_valid) begin
      qb_d = next_uc ? '0 : qb_step;
      if (next_pch)     uc_d = '0;
      else if (next_uc) uc_d = uc_step;
      if (next_round)   id_d = '0;
      else if (next_id) id_d = (id_q == '1) ? id_q : id_q + 1'b1;
      if (next_opcode)     round_d = '0;
      else if (next_round) round_d = (round_q == '1) ? round_q : round_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PSU_READY;
      qb_q       <= '0;
      uc_q       <= '0;
      id_q       <= '0;
      round_q    <= '0;
      done_vld_q <= 1'b0;
      done_op_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      qb_q       <= qb_d;
      uc_q       <= uc_d;
      id_q       <= id_d;
      round_q    <= round_d;
      done_vld_q <= done_vld_d;
      done_op_q  <= done_op_d;
      err_q      <= err_d;
    end
  end

  assign state         = state_q;
  assign qb_counter0   = qb_q;
  assign uc_counter0   = uc_q;
  assign id_counter    = id_q;
  assign round_counter = round_q;
  assign done_valid    = done_vld_q;
  assign done_opcode   = done_op_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_psu_seq.sv
// Bench for psu_seq: queue-based reference model drives a decoder model; retired opcodes go through a scoreboard.
module tb_psu_seq;
  import psu_seq_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [OPCODE_BW-1:0] in_opcode = '0;
  logic [IDLEN_BW-1:0]  in_id_len = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 next_uc = 1'b0, next_pch = 1'b0, next_id = 1'b0;
  logic                 next_round = 1'b0, next_opcode = 1'b0, next_state = 1'b0;
  logic                 psu_valid;
  logic [OPCODE_BW-1:0] opcode_running;
  logic [IDLEN_BW-1:0]  id_len;
  logic                 state;
  logic [QBADDR_BW-1:0] qb_counter0;
  logic [UCADDR_BW-1:0] uc_counter0;
  logic [IDLEN_BW-1:0]  id_counter;
  logic [ROUND_BW-1:0]  round_counter;
  logic                 done_valid;
  logic [OPCODE_BW-1:0] done_opcode;
  logic                 err_underflow;

  psu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_opcode(in_opcode), .in_id_len(in_id_len), .in_valid(in_valid), .in_ready(in_ready),
    .next_uc(next_uc), .next_pch(next_pch), .next_id(next_id), .next_round(next_round),
    .next_opcode(next_opcode), .next_state(next_state),
    .psu_valid(psu_valid), .opcode_running(opcode_running), .id_len(id_len), .state(state),
    .qb_counter0(qb_counter0), .uc_counter0(uc_counter0), .id_counter(id_counter),
    .round_counter(round_counter), .done_valid(done_valid), .done_opcode(done_opcode),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending work, sweep position and flags.
  int m_op[$];
  int m_il[$];
  int exp_done[$];
  int m_qb, m_uc, m_id, m_rnd;
  bit m_state, m_done_v, m_err;
  bit run_en;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_op.delete(); m_il.delete(); exp_done.delete();
    m_qb = 0; m_uc = 0; m_id = 0; m_rnd = 0;
    m_state = 0; m_done_v = 0; m_err = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, (m_op.size() < QDEPTH) ? 1 : 0);
    chk("psu_valid", psu_valid, (m_op.size() != 0) ? 1 : 0);
    chk("opcode_running", opcode_running, (m_op.size() != 0) ? m_op[0] : 0);
    chk("id_len", id_len, (m_op.size() != 0) ? ((m_il[0] == 0) ? 1 : m_il[0]) : 0);
    chk("state", state, m_state);
    chk("qb_counter0", qb_counter0, m_qb);
    chk("uc_counter0", uc_counter0, m_uc);
    chk("id_counter", id_counter, m_id);
    chk("round_counter", round_counter, m_rnd);
    chk("done_valid", done_valid, m_done_v);
    chk("err_underflow", err_underflow, m_err);
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input bit iv, input int op, input int il, input bit force_retire);
    bit nuc, npch, nid, nround, nop, nst, push, pop;
    int eff;
    check_outputs();
    nuc = 0; npch = 0; nid = 0; nround = 0; nop = 0;
    if (m_state && m_op.size() != 0) begin
      eff    = (m_il[0] == 0) ? 1 : m_il[0];
      nuc    = (m_qb + NUM_QBCTRL >= NUM_QB);
      npch   = nuc && (m_uc + NUM_UCC >= NUM_UC);
      nid    = npch;
      nround = nid && (m_id == eff - 1);
      nop    = (m_op[0] == OP_RUN_ESM) ? (nround && m_rnd == CODE_DIST - 1) : nround;
    end
    if (force_retire) nop = 1;
    nst = (m_op.size() != 0 || iv) && run_en && ($urandom_range(0, 3) != 0);

    in_valid = iv; in_opcode = OPCODE_BW'(op); in_id_len = IDLEN_BW'(il);
    next_uc = nuc; next_pch = npch; next_id = nid; next_round = nround;
    next_opcode = nop; next_state = nst;

    push = iv && (m_op.size() < QDEPTH);
    pop  = nop && (m_op.size() != 0);
    if (nop && m_op.size() == 0) m_err = 1;
    if (m_state && m_op.size() != 0) begin
      m_qb  = nuc ? 0 : (m_qb + NUM_QBCTRL) % NUM_QB;
      m_uc  = npch ? 0 : (nuc ? (m_uc + NUM_UCC) % NUM_UC : m_uc);
      m_id  = nround ? 0 : (nid ? m_id + 1 : m_id);
      m_rnd = nop ? 0 : (nround ? m_rnd + 1 : m_rnd);
    end
    m_done_v = pop;
    if (pop) begin void'(m_op.pop_front()); void'(m_il.pop_front()); end
    if (push) begin m_op.push_back(op); m_il.push_back(il); exp_done.push_back(op); end
    m_state = nst;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (m_op.size() != 0 || m_done_v); i++) step(0, 0, 0, 0);
    if (m_op.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d entries still queued", m_op.size());
    end
  endtask

  // Scoreboard: each retirement must match the oldest accepted opcode.
  int sb_exp;
  always @(negedge clk) begin
    if (rst_n && done_valid === 1'b1) begin
      if (exp_done.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL done_unexpected: got opcode %0d expected no retirement", done_opcode);
      end else begin
        sb_exp = exp_done.pop_front();
        chk("done_opcode", done_opcode, sb_exp);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    model_clear();
    run_en = 0;
    // Reset held with a push request pending.
    in_valid = 1; in_opcode = OP_LQI; in_id_len = 4'd2; rst_n = 0;
    repeat (3) begin @(negedge clk); check_outputs(); end
    rst_n = 1;

    // Single LQI sweep.
    run_en = 1;
    step(1, OP_LQI, 2, 0);
    drain();

    // Fill to full with the datapath parked, then release it under pressure.
    run_en = 0;
    step(1, OP_LQM_X, 1, 0);
    step(1, OP_LQM_Z, 0, 0);
    step(1, OP_MERGE, 1, 0);
    step(1, OP_SPLIT, 2, 0);
    step(1, OP_LQI, 1, 0);
    step(1, OP_LQI, 1, 0);
    run_en = 1;
    for (int i = 0; i < 40; i++) step(1, $urandom_range(1, 6), $urandom_range(0, 2), 0);
    drain();

    // ESM rounds.
    step(1, OP_RUN_ESM, 1, 0);
    drain();

    // Retire request with nothing queued.
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(1, OP_LQI, 1, 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) == 0), $urandom_range(1, 6), $urandom_range(0, 3), 0);
    drain();
    repeat (2) step(0, 0, 0, 0);
    chk("scoreboard_empty", exp_done.size(), 0);

    // Reset in the middle of a sweep.
    step(1, OP_LQI, 2, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_state && m_op.size() != 0 && m_qb == 4 && m_id == 1) found = 1;
      else step(1, OP_MERGE, 1, 0);
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL midrun_timeout: sweep position qb=4 id=1 never reached");
    end
    #1 rst_n = 0;
    #1;
    chk("async_psu_valid", psu_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_opcode", opcode_running, 0);
    chk("async_state", state, 0);
    chk("async_qb", qb_counter0, 0);
    chk("async_id", id_counter, 0);
    chk("async_done", done_valid, 0);
    model_clear();
    in_valid = 0; next_state = 0; next_uc = 0; next_pch = 0;
    next_id = 0; next_round = 0; next_opcode = 0;
    @(negedge clk); check_outputs();
    rst_n = 1;
    repeat (4) step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
